// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: ID-stage data-hazard detector for the 5-stage ARM pipeline.
// Compares the ID-stage source registers against the EXE and MEM write-back
// destinations and raises a zero-latency stall request.
// It also keeps a registered copy of that request and a saturating
// stall-cycle counter for debug and performance monitoring.
//
// Optional build macro HAZARD_FWD_EN: for pipelines with a forwarding unit.
// It adds the exe_mem_r_en input, and only a load in EXE that matches a
// source register stalls. All other matches are covered by forwarding.
module hazard_detect_unit #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] rn_addr,
   input  logic [REG_W-1:0] rm_addr,
   input  logic             two_src,
   input  logic             exe_wb_en,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             stat_clr,
`ifdef HAZARD_FWD_EN
   input  logic             exe_mem_r_en,
`endif
   output logic             hazard,
   output logic             hazard_q,
   output logic [CNT_W-1:0] stall_count
);

   // Rn is always read. Rm counts only when the instruction really uses it.
   // Register 0 is an ordinary register, so it gets no exemption.
   logic exe_rn;
   logic mem_rn;
   logic exe_rm;
   logic mem_rm;
   logic hazard_raw;

   // Source/destination match terms; a destination only counts when it will be written
   always_comb begin
      exe_rn = exe_wb_en & (exe_dest == rn_addr);
      mem_rn = mem_wb_en & (mem_dest == rn_addr);
      exe_rm = exe_wb_en & (exe_dest == rm_addr) & two_src;
      mem_rm = mem_wb_en & (mem_dest == rm_addr) & two_src;
   end

`ifdef HAZARD_FWD_EN
   // With forwarding, only a load in EXE cannot supply its result in time
   always_comb begin
      hazard_raw = exe_mem_r_en & (exe_rn | exe_rm);
   end
`else
   // Without forwarding, any pending write to a source register stalls
   always_comb begin
      hazard_raw = exe_rn | mem_rn | exe_rm | mem_rm;
   end
`endif

   // The stall request is suppressed while reset is held
   always_comb begin
      hazard = rst_n & hazard_raw;
   end

   // One-cycle delayed copy of the stall request for debug visibility
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hazard_q <= 1'b0;
      end else begin
         hazard_q <= hazard;
      end
   end

   // Count stalled cycles. A clear wins over an increment.
   // The counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stat_clr) begin
         stall_count <= '0;
      end else if (hazard && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: directed, table-driven bench for hazard_detect_unit.
// Two instances share their inputs: one with the default 16-bit counter, and
// one with a 4-bit counter so that saturation can be reached quickly.
module tb_hazard_detect_unit;

   localparam int REG_W = 4;

   logic             clk;
   logic             rst_n;
   logic [REG_W-1:0] rn_addr;
   logic [REG_W-1:0] rm_addr;
   logic             two_src;
   logic             exe_wb_en;
   logic [REG_W-1:0] exe_dest;
   logic             mem_wb_en;
   logic [REG_W-1:0] mem_dest;
   logic             stat_clr;
   logic             exe_mem_r_en;
   logic             hazard;
   logic             hazard_q;
   logic [15:0]      stall_count;
   logic             hazard_s;
   logic             hazard_q_s;
   logic [3:0]       stall_count_s;

   hazard_detect_unit #(.REG_W(REG_W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .rn_addr(rn_addr), .rm_addr(rm_addr),
      .two_src(two_src), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .stat_clr(stat_clr),
`ifdef HAZARD_FWD_EN
      .exe_mem_r_en(exe_mem_r_en),
`endif
      .hazard(hazard), .hazard_q(hazard_q), .stall_count(stall_count)
   );

   hazard_detect_unit #(.REG_W(REG_W), .CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .rn_addr(rn_addr), .rm_addr(rm_addr),
      .two_src(two_src), .exe_wb_en(exe_wb_en), .exe_dest(exe_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .stat_clr(stat_clr),
`ifdef HAZARD_FWD_EN
      .exe_mem_r_en(exe_mem_r_en),
`endif
      .hazard(hazard_s), .hazard_q(hazard_q_s), .stall_count(stall_count_s)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One stimulus vector.
   // exp is the expected hazard in the default build; exp_fwd is the
   // expected hazard with forwarding enabled.
   typedef struct {
      logic [3:0] rn;
      logic [3:0] rm;
      logic       two;
      logic       ewb;
      logic [3:0] ed;
      logic       mwb;
      logic [3:0] md;
      logic       ld;
      logic       exp;
      logic       exp_fwd;
   } vec_t;

   vec_t vecs[17];

   // Scoreboard
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic expect_val(input logic [15:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act);
      logic [15:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      expect_val(exp);
      check(name, act);
   endtask

   // Drivers
   task automatic apply(input vec_t v);
      rn_addr      = v.rn;
      rm_addr      = v.rm;
      two_src      = v.two;
      exe_wb_en    = v.ewb;
      exe_dest     = v.ed;
      mem_wb_en    = v.mwb;
      mem_dest     = v.md;
      exe_mem_r_en = v.ld;
   endtask

   task automatic drive_zero();
      rn_addr = '0; rm_addr = '0; two_src = 1'b0; exe_wb_en = 1'b0;
      exe_dest = 4'd5; mem_wb_en = 1'b0; mem_dest = 4'd6; exe_mem_r_en = 1'b0;
   endtask

   // A load in EXE writing r2 that the ID stage reads: stalls in both builds
   task automatic drive_hz();
      rn_addr = 4'd2; rm_addr = '0; two_src = 1'b0; exe_wb_en = 1'b1;
      exe_dest = 4'd2; mem_wb_en = 1'b0; mem_dest = '0; exe_mem_r_en = 1'b1;
   endtask

   initial begin
      int   exp_cnt;
      logic e;
      //          rn     rm    two   ewb   ed     mwb   md     ld    exp   fwd
      vecs[0]  = '{4'd1, 4'd0, 1'b0, 1'b0, 4'd1,  1'b0, 4'd1,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'd1, 4'd0, 1'b0, 1'b1, 4'd1,  1'b0, 4'd1,  1'b0, 1'b1, 1'b0};
      vecs[2]  = '{4'd1, 4'd0, 1'b0, 1'b0, 4'd1,  1'b1, 4'd1,  1'b0, 1'b1, 1'b0};
      vecs[3]  = '{4'd1, 4'd0, 1'b0, 1'b0, 4'd1,  1'b0, 4'd1,  1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'd0, 4'd1, 1'b0, 1'b1, 4'd1,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'd0, 4'd1, 1'b1, 1'b1, 4'd1,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
      vecs[6]  = '{4'd0, 4'd1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 1'b0, 1'b0};
      vecs[7]  = '{4'd0, 4'd1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 1'b1, 1'b0};
      vecs[8]  = '{4'd0, 4'd0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd5,  1'b1, 1'b1, 1'b1};
      vecs[9]  = '{4'd0, 4'd0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
      vecs[10] = '{4'd3, 4'd3, 1'b1, 1'b1, 4'd3,  1'b1, 4'd3,  1'b1, 1'b1, 1'b1};
      vecs[11] = '{4'd4, 4'd5, 1'b1, 1'b1, 4'd6,  1'b1, 4'd7,  1'b1, 1'b0, 1'b0};
      vecs[12] = '{4'd2, 4'd0, 1'b0, 1'b1, 4'd2,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
      vecs[13] = '{4'd2, 4'd0, 1'b0, 1'b1, 4'd2,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1};
      vecs[14] = '{4'd2, 4'd0, 1'b0, 1'b0, 4'd2,  1'b1, 4'd2,  1'b1, 1'b1, 1'b0};
      vecs[15] = '{4'd8, 4'd9, 1'b1, 1'b1, 4'd9,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1};
      vecs[16] = '{4'd15,4'd0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b1, 1'b0};

      // Reset state, and the hazard output held low during reset
      rst_n = 1'b0; stat_clr = 1'b0; drive_zero();
      #1;
      chk("reset_hazard", {15'd0, hazard}, 16'd0);
      chk("reset_hazard_q", {15'd0, hazard_q}, 16'd0);
      chk("reset_count", stall_count, 16'd0);
      drive_hz();
      #1;
      chk("hazard_forced_low_in_reset", {15'd0, hazard}, 16'd0);
      drive_zero();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_hazard_q", {15'd0, hazard_q}, 16'd0);
      chk("post_reset_count", stall_count, 16'd0);

      // Table-driven combinational and registered checks
      exp_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         apply(vecs[i]);
`ifdef HAZARD_FWD_EN
         e = vecs[i].exp_fwd;
`else
         e = vecs[i].exp;
`endif
         #1;
         chk($sformatf("vec%0d_hazard", i), {15'd0, hazard}, {15'd0, e});
         @(posedge clk); #1;
         chk($sformatf("vec%0d_hazard_q", i), {15'd0, hazard_q}, {15'd0, e});
         if (e) exp_cnt++;
      end
      chk("table_count", stall_count, 16'(exp_cnt));
      chk("table_count_small", {12'd0, stall_count_s}, 16'(exp_cnt));

      // Clear has priority over an increment in the same cycle
      @(negedge clk); drive_zero();
      @(posedge clk);
      @(negedge clk); drive_hz(); stat_clr = 1'b1;
      #1;
      chk("clr_cycle_hazard", {15'd0, hazard}, 16'd1);
      chk("clr_cycle_hazard_q_lags", {15'd0, hazard_q}, 16'd0);
      @(posedge clk); #1;
      chk("clr_wins_count", stall_count, 16'd0);
      chk("clr_hazard_q", {15'd0, hazard_q}, 16'd1);

      // Hazard held for three cycles
      @(negedge clk); stat_clr = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("hold_count_%0d", c), stall_count, 16'(c));
      end
      @(negedge clk); drive_zero();
      #1;
      chk("drop_hazard", {15'd0, hazard}, 16'd0);
      chk("drop_hazard_q_lags", {15'd0, hazard_q}, 16'd1);
      @(posedge clk); #1;
      chk("drop_hazard_q", {15'd0, hazard_q}, 16'd0);
      chk("drop_count_holds", stall_count, 16'd3);

      // Saturation of the 4-bit counter over 20 hazard cycles
      @(negedge clk); stat_clr = 1'b1;
      @(negedge clk); stat_clr = 1'b0; drive_hz();
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 15) chk("small_at_15", {12'd0, stall_count_s}, 16'd15);
      end
      chk("small_saturated", {12'd0, stall_count_s}, 16'd15);
      chk("wide_count_20", stall_count, 16'd20);

      // Asynchronous reset between clock edges
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("async_count", stall_count, 16'd0);
      chk("async_count_small", {12'd0, stall_count_s}, 16'd0);
      chk("async_hazard_q", {15'd0, hazard_q}, 16'd0);
      chk("async_hazard", {15'd0, hazard}, 16'd0);

      // The first rising edge with reset released is counted
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("release_hazard", {15'd0, hazard}, 16'd1);
      @(posedge clk); #1;
      chk("release_first_count", stall_count, 16'd1);
      chk("release_hazard_q", {15'd0, hazard_q}, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Data-hazard detector for the 5-stage ARM pipeline, located in the ID stage.
- Compares the ID-stage source register addresses against the write-back destinations of the instructions in the EXE and MEM stages.
- Raises `hazard` combinationally in the same cycle so the IF/ID stage can be stalled.
- Also provides a registered copy of the hazard flag and a saturating stall-cycle counter for debug and performance monitoring.

Parameters:
- REG_W, 4, width of register addresses (16 architectural registers).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- rn_addr  input  REG_W  first source register address of the ID-stage instruction.
- rm_addr  input  REG_W  second source register address of the ID-stage instruction.
- two_src  input  1  high when the ID-stage instruction actually reads rm_addr.
- exe_wb_en  input  1  the EXE-stage instruction will write the register file.
- exe_dest  input  REG_W  destination register of the EXE-stage instruction.
- mem_wb_en  input  1  the MEM-stage instruction will write the register file.
- mem_dest  input  REG_W  destination register of the MEM-stage instruction.
- stat_clr  input  1  synchronous clear of stall_count.
- hazard  output  1  combinational stall request.
- hazard_q  output  1  hazard registered by one cycle.
- stall_count  output  CNT_W  number of cycles in which hazard was high, saturating.

Behaviour:
- Match terms, all purely combinational:
  - exe_rn = exe_wb_en & (exe_dest == rn_addr)
  - mem_rn = mem_wb_en & (mem_dest == rn_addr)
  - exe_rm = exe_wb_en & (exe_dest == rm_addr) & two_src
  - mem_rm = mem_wb_en & (mem_dest == rm_addr) & two_src
- hazard = rst_n & (exe_rn | mem_rn | exe_rm | mem_rm).
  - Zero latency: no clock edge between an input change and the hazard change.
  - hazard is forced to 0 while rst_n is low.
- Rn is always checked. Rm is checked only when two_src = 1.
- A matching destination is ignored when its wb_en is 0, including register 0.
- Address 0 is an ordinary register; there is no zero-register exemption.
- EXE and MEM both matching the same source gives a single hazard (logical OR). The same applies when rn_addr equals rm_addr.
- hazard_q:
  - On rst_n low, asynchronously cleared to 0.
  - Otherwise, on each rising clk edge, hazard_q <= hazard.
- stall_count:
  - On rst_n low, asynchronously cleared to 0.
  - Otherwise, on each rising clk edge, apply the first matching rule:
    - stat_clr = 1: set to 0. stat_clr has priority over increment.
    - hazard = 1 and stall_count is not all-ones: increment by 1.
    - Otherwise: hold.
  - Saturates at 2^CNT_W - 1; it never wraps.
- Reset asserted mid-operation clears all state immediately. After rst_n deasserts, the first counted edge is the first rising edge with rst_n high.
- X or unknown inputs are not required to be handled; the bench drives known values.

Optional Feature:
- Macro HAZARD_FWD_EN, for pipelines that include a forwarding unit.
- When defined:
  - Adds input exe_mem_r_en (1 bit): the EXE-stage instruction is a load.
  - hazard is then exe_mem_r_en & (exe_rn | exe_rm).
  - MEM-stage matches and non-load EXE matches no longer stall, because the forwarding path covers them.
  - hazard_q and stall_count track this reduced hazard.
- When not defined:
  - exe_mem_r_en does not exist.
  - The full EXE/MEM comparison described above applies.

Test Plan:
- Reset / all-zero: all inputs 0 with rst_n toggled low then high -> hazard = 0, hazard_q = 0, stall_count = 0.
- Rn vs EXE: rn_addr = 1, exe_dest = 1, mem_dest = 1.
  - exe_wb_en = 0, mem_wb_en = 0 -> hazard = 0.
  - exe_wb_en = 1 -> hazard = 1.
  - Then exe_wb_en = 0, mem_wb_en = 1 -> hazard = 1.
  - Then mem_wb_en = 0 -> hazard = 0.
- Rm gating by two_src: rn_addr = 0, rm_addr = 1, exe_dest = 1, exe_wb_en = 1.
  - two_src = 0 -> hazard = 0.
  - two_src = 1 -> hazard = 1.
  - Repeat with mem_wb_en = 1, exe_wb_en = 0: same result.
- Register timing: hold a hazard for 3 cycles.
  - hazard_q follows hazard one cycle later.
  - stall_count = 3.
  - Pulse stat_clr in the same cycle as a hazard -> stall_count = 0 on that edge.
- Saturation and async reset: CNT_W = 4, hazard held for 20 cycles.
  - stall_count stops at 15.
  - Drop rst_n between edges -> stall_count and hazard_q become 0 immediately, and hazard = 0.
- With HAZARD_FWD_EN: rn_addr = 2 = exe_dest, exe_wb_en = 1.
  - exe_mem_r_en = 0 -> hazard = 0.
  - exe_mem_r_en = 1 -> hazard = 1.
  - A MEM-only match -> hazard = 0.
